// File: rtl/pipeline_controller_pkg.sv
// Shared encodings and control-bundle types for the RV32I pipeline controller.
package pipeline_controller_pkg;

  localparam logic [4:0] OPC_R      = 5'b01100;
  localparam logic [4:0] OPC_I      = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic [3:0] op;
    logic       alu_src;
    logic       s_type;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [2:0] funct3;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic ecall;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // alt selects SUB for funct3=000 and SRA for funct3=101 (instr[30]).
  function automatic logic [3:0] alu_op_decode(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pipeline_controller_hazard_unit.sv
// Combinational hazard detection (load-use / RAW) and EX-stage forwarding selects.
module pipeline_controller_hazard_unit
  import pipeline_controller_pkg::*;
#(
  parameter int FORWARDING = 1,
  parameter int REG_AW     = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic              hazard,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  function automatic logic dep(input logic wr, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] rs, input logic use_rs);
    return wr && (rd != '0) && use_rs && (rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic mwr, input logic [REG_AW-1:0] mrd,
                                         input logic wwr, input logic [REG_AW-1:0] wrd);
    logic [1:0] sel;
    if (mwr && (mrd != '0) && (mrd == rs))      sel = FWD_EXMEM;
    else if (wwr && (wrd != '0) && (wrd == rs)) sel = FWD_MEMWB;
    else                                        sel = FWD_RF;
    return sel;
  endfunction

  logic load_use, raw_ex, raw_mem;

  always_comb begin
    load_use = dep(ex_mem_to_reg, ex_rd, id_rs1, id_use_rs1) ||
               dep(ex_mem_to_reg, ex_rd, id_rs2, id_use_rs2);
    raw_ex   = dep(ex_reg_write, ex_rd, id_rs1, id_use_rs1) ||
               dep(ex_reg_write, ex_rd, id_rs2, id_use_rs2);
    raw_mem  = dep(mem_reg_write, mem_rd, id_rs1, id_use_rs1) ||
               dep(mem_reg_write, mem_rd, id_rs2, id_use_rs2);
    // Without bypass paths every in-flight producer in EX or MEM must be waited out.
    hazard   = (FORWARDING != 0) ? load_use : (raw_ex || raw_mem);
    fwd_a    = FWD_RF;
    fwd_b    = FWD_RF;
    if (FORWARDING != 0) begin
      fwd_a = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
      fwd_b = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Registered RV32I pipeline control: ID decode, ID/EX..MEM/WB control registers,
// hazard stall/flush management, forwarding selects and ecall halt.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int FORWARDING = 1,
  parameter int EXT_BRANCH = 1,
  parameter int REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        id_funct7,
  input  logic [2:0]        id_funct3,
  input  logic [4:0]        id_op_code,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_cond_true,
  input  logic              wb_halt_req,
  output logic [3:0]        ex_op,
  output logic              ex_alu_src,
  output logic              ex_s_type,
  output logic              ex_branch,
  output logic              ex_jal,
  output logic              ex_jalr,
  output logic [2:0]        ex_funct3,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              wb_ecall,
  output logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              halted
);

  ctrl_t id_ctrl;
  logic  id_use_rs1, id_use_rs2;
  logic  r_legal, i_legal, br_legal;

  always_comb begin
    id_ctrl    = CTRL_BUBBLE;
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    r_legal    = (id_funct7 == F7_BASE) ||
                 ((id_funct7 == F7_ALT) && ((id_funct3 == 3'b000) || (id_funct3 == 3'b101)));
    i_legal    = (id_funct3 == 3'b001) ? (id_funct7 == F7_BASE) :
                 (id_funct3 == 3'b101) ? ((id_funct7 == F7_BASE) || (id_funct7 == F7_ALT)) :
                 1'b1;
    br_legal   = (id_funct3[2:1] == 2'b00) || ((EXT_BRANCH != 0) && id_funct3[2]);
    case (id_op_code)
      OPC_R: if (r_legal) begin
        id_ctrl.ex.op        = alu_op_decode(id_funct3, id_funct7[5]);
        id_ctrl.wb.reg_write = 1'b1;
        id_use_rs1           = 1'b1;
        id_use_rs2           = 1'b1;
      end
      OPC_I: if (i_legal) begin
        // Only srai takes instr[30]; for addi it is an immediate bit, not SUB.
        id_ctrl.ex.op        = alu_op_decode(id_funct3, (id_funct3 == 3'b101) && id_funct7[5]);
        id_ctrl.ex.alu_src   = 1'b1;
        id_ctrl.wb.reg_write = 1'b1;
        id_use_rs1           = 1'b1;
      end
      OPC_LOAD: begin
        id_ctrl.ex.op          = ALU_ADD;
        id_ctrl.ex.alu_src     = 1'b1;
        id_ctrl.mem.mem_to_reg = 1'b1;
        id_ctrl.wb.reg_write   = 1'b1;
        id_use_rs1             = 1'b1;
      end
      OPC_STORE: begin
        id_ctrl.ex.op         = ALU_ADD;
        id_ctrl.ex.alu_src    = 1'b1;
        id_ctrl.ex.s_type     = 1'b1;
        id_ctrl.mem.mem_write = 1'b1;
        id_use_rs1            = 1'b1;
        id_use_rs2            = 1'b1;
      end
      OPC_BRANCH: if (br_legal) begin
        id_ctrl.ex.op     = ALU_SUB;
        id_ctrl.ex.branch = 1'b1;
        id_ctrl.ex.funct3 = id_funct3;
        id_use_rs1        = 1'b1;
        id_use_rs2        = 1'b1;
      end
      OPC_JAL: begin
        id_ctrl.ex.op        = ALU_ADD;
        id_ctrl.ex.jal       = 1'b1;
        id_ctrl.wb.reg_write = 1'b1;
      end
      OPC_JALR: begin
        id_ctrl.ex.op        = ALU_ADD;
        id_ctrl.ex.alu_src   = 1'b1;
        id_ctrl.ex.jalr      = 1'b1;
        id_ctrl.wb.reg_write = 1'b1;
        id_use_rs1           = 1'b1;
      end
      OPC_LUI: begin
        id_ctrl.ex.op        = ALU_PASSB;
        id_ctrl.ex.alu_src   = 1'b1;
        id_ctrl.wb.reg_write = 1'b1;
      end
      OPC_SYSTEM: id_ctrl.wb.ecall = 1'b1;
      default: ;
    endcase
  end

  ctrl_t             idex_ctrl_q, idex_ctrl_d;
  logic [REG_AW-1:0] idex_rs1_q, idex_rs1_d, idex_rs2_q, idex_rs2_d, idex_rd_q, idex_rd_d;
  mem_ctrl_t         exmem_mem_q, exmem_mem_d;
  wb_ctrl_t          exmem_wb_q, exmem_wb_d;
  logic [REG_AW-1:0] exmem_rd_q, exmem_rd_d;
  wb_ctrl_t          memwb_wb_q, memwb_wb_d;
  logic              memwb_mem_to_reg_q, memwb_mem_to_reg_d;
  logic [REG_AW-1:0] memwb_rd_q, memwb_rd_d;
  logic              halted_q, halted_d;

  logic hazard, redirect, halt_now, drain;

  pipeline_controller_hazard_unit #(
    .FORWARDING (FORWARDING),
    .REG_AW     (REG_AW)
  ) u_hazard_unit (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_rs1        (idex_rs1_q),
    .ex_rs2        (idex_rs2_q),
    .ex_rd         (idex_rd_q),
    .ex_reg_write  (idex_ctrl_q.wb.reg_write),
    .ex_mem_to_reg (idex_ctrl_q.mem.mem_to_reg),
    .mem_rd        (exmem_rd_q),
    .mem_reg_write (exmem_wb_q.reg_write),
    .wb_rd         (memwb_rd_q),
    .wb_reg_write  (memwb_wb_q.reg_write),
    .hazard        (hazard),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  always_comb begin
    redirect   = idex_ctrl_q.ex.jal || idex_ctrl_q.ex.jalr ||
                 (idex_ctrl_q.ex.branch && ex_cond_true);
    halt_now   = memwb_wb_q.ecall && wb_halt_req;
    // Everything younger than the halting ecall is killed from the same edge on.
    drain      = halted_q || halt_now;
    stall_pc   = halted_q || (hazard && !redirect);
    stall_ifid = stall_pc;
    flush_ifid = redirect;
    flush_idex = halted_q || redirect || hazard;
    halted_d   = halted_q || halt_now;
  end

  always_comb begin
    idex_ctrl_d = id_ctrl;
    idex_rs1_d  = id_rs1;
    idex_rs2_d  = id_rs2;
    idex_rd_d   = id_rd;
    if (flush_idex) begin
      idex_ctrl_d = CTRL_BUBBLE;
      idex_rs1_d  = '0;
      idex_rs2_d  = '0;
      idex_rd_d   = '0;
    end
    exmem_mem_d        = drain ? '0 : idex_ctrl_q.mem;
    exmem_wb_d         = drain ? '0 : idex_ctrl_q.wb;
    exmem_rd_d         = drain ? '0 : idex_rd_q;
    memwb_wb_d         = drain ? '0 : exmem_wb_q;
    memwb_mem_to_reg_d = drain ? 1'b0 : exmem_mem_q.mem_to_reg;
    memwb_rd_d         = drain ? '0 : exmem_rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ctrl_q        <= CTRL_BUBBLE;
      idex_rs1_q         <= '0;
      idex_rs2_q         <= '0;
      idex_rd_q          <= '0;
      exmem_mem_q        <= '0;
      exmem_wb_q         <= '0;
      exmem_rd_q         <= '0;
      memwb_wb_q         <= '0;
      memwb_mem_to_reg_q <= 1'b0;
      memwb_rd_q         <= '0;
      halted_q           <= 1'b0;
    end else begin
      idex_ctrl_q        <= idex_ctrl_d;
      idex_rs1_q         <= idex_rs1_d;
      idex_rs2_q         <= idex_rs2_d;
      idex_rd_q          <= idex_rd_d;
      exmem_mem_q        <= exmem_mem_d;
      exmem_wb_q         <= exmem_wb_d;
      exmem_rd_q         <= exmem_rd_d;
      memwb_wb_q         <= memwb_wb_d;
      memwb_mem_to_reg_q <= memwb_mem_to_reg_d;
      memwb_rd_q         <= memwb_rd_d;
      halted_q           <= halted_d;
    end
  end

  assign ex_op          = idex_ctrl_q.ex.op;
  assign ex_alu_src     = idex_ctrl_q.ex.alu_src;
  assign ex_s_type      = idex_ctrl_q.ex.s_type;
  assign ex_branch      = idex_ctrl_q.ex.branch;
  assign ex_jal         = idex_ctrl_q.ex.jal;
  assign ex_jalr        = idex_ctrl_q.ex.jalr;
  assign ex_funct3      = idex_ctrl_q.ex.funct3;
  assign mem_mem_write  = exmem_mem_q.mem_write && !drain;
  assign mem_mem_to_reg = exmem_mem_q.mem_to_reg;
  assign wb_reg_write   = memwb_wb_q.reg_write && !halted_q;
  assign wb_mem_to_reg  = memwb_mem_to_reg_q;
  assign wb_ecall       = memwb_wb_q.ecall;
  assign wb_rd          = memwb_rd_q;
  assign halted         = halted_q;

endmodule
